rename_ckpt: RTL and testbench

Parametrised register-rename stage with multi-checkpoint branch recovery; it sits between the decode skid buffer and dispatch/ROB. Each accepted instruction gets its architectural sources mapped to physical registers, a new physical destination from an internal circular free list, and a wrapping ROB tag. Up to NUM_CKPT unresolved branches each snapshot the map table, free-list head and ROB-tag counter. A mispredict on any one of them restores that snapshot and discards all younger checkpoints in a single cycle.

---
 rtl/rename_ckpt.sv | 171 +++++++++++++++++
 tb/tb_rename_ckpt.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_ckpt.sv
// Register-rename stage: map table, circular free list and wrapping ROB tag, with
// NUM_CKPT branch checkpoints that restore map/free-list head/ROB counter in one cycle.
module rename_ckpt #(
    parameter  int NUM_AREGS = 32,
    parameter  int NUM_PREGS = 128,
    parameter  int ROB_DEPTH = 16,
    parameter  int NUM_CKPT  = 4,
    parameter  int PAYLOAD_W = 64,
    localparam int AW        = $clog2(NUM_AREGS),
    localparam int PW        = $clog2(NUM_PREGS),
    localparam int TW        = $clog2(ROB_DEPTH),
    localparam int CW        = $clog2(NUM_CKPT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic [AW-1:0]        rs1,
    input  logic [AW-1:0]        rs2,
    input  logic [AW-1:0]        rd,
    input  logic [6:0]           opcode,
    input  logic [PAYLOAD_W-1:0] payload_in,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic [PW-1:0]        ps1,
    output logic [PW-1:0]        ps2,
    output logic [PW-1:0]        pd_old,
    output logic [PW-1:0]        pd_new,
    output logic [TW-1:0]        rob_tag,
    output logic [CW-1:0]        ckpt_id,
    output logic [PAYLOAD_W-1:0] payload_out,
    input  logic                 free_valid,
    input  logic [PW-1:0]        free_preg,
    input  logic                 resolve_valid,
    input  logic [CW-1:0]        resolve_ckpt,
    input  logic                 resolve_mispredict
);

    localparam int FL = NUM_PREGS - NUM_AREGS;
    localparam int FW = $clog2(FL);
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Free-list pointer: the wrap bit distinguishes full from empty with a
    // non-power-of-two depth.
    typedef struct packed {
        logic          wrap;
        logic [FW-1:0] idx;
    } fl_ptr_t;

    typedef logic [NUM_AREGS-1:0][PW-1:0] map_t;

    map_t                map_q, map_d;
    logic [PW-1:0]       fl_mem [FL];
    fl_ptr_t             fl_head, fl_tail;
    logic [TW-1:0]       rob_ctr, rob_next;

    map_t                ck_map [NUM_CKPT];
    fl_ptr_t             ck_flh [NUM_CKPT];
    logic [TW-1:0]       ck_rob [NUM_CKPT];
    logic [NUM_CKPT-1:0] ck_done;
    logic [CW:0]         ck_head, ck_tail, ck_count;
    logic [CW-1:0]       res_off;

    logic          write_pd, is_br, flush, accept, alloc, push;
    logic          fl_empty, ckpt_full, res_live, retire;
    logic [PW-1:0] head_preg;

    function automatic fl_ptr_t fl_inc(input fl_ptr_t p);
        fl_ptr_t n;
        if (p.idx == FW'(FL - 1)) begin
            n.idx  = '0;
            n.wrap = ~p.wrap;
        end else begin
            n.idx  = p.idx + FW'(1);
            n.wrap = p.wrap;
        end
        return n;
    endfunction

    always_comb begin
        write_pd  = (opcode != OP_STORE) && (opcode != OP_BRANCH) && (rd != '0);
        is_br     = (opcode == OP_BRANCH);
        flush     = resolve_valid && resolve_mispredict;
        fl_empty  = (fl_head == fl_tail);
        ck_count  = ck_tail - ck_head;
        ckpt_full = (ck_count == (CW+1)'(NUM_CKPT));
        // A slot is live when its distance from the oldest slot is below the live count.
        res_off   = resolve_ckpt - ck_head[CW-1:0];
        res_live  = ({1'b0, res_off} < ck_count);
        ready_in  = reset && !flush && (ready_out || !valid_out)
                    && (!write_pd || !fl_empty) && (!is_br || !ckpt_full);
        accept    = valid_in && ready_in;
        alloc     = accept && write_pd;
        push      = free_valid && (free_preg != '0);
        retire    = !flush && (ck_count != '0) && ck_done[ck_head[CW-1:0]];
        head_preg = fl_mem[fl_head.idx];
        rob_next  = (rob_ctr == TW'(ROB_DEPTH - 1)) ? '0 : rob_ctr + TW'(1);
        // NOTE: map_d starts as a full copy so every path assigns it and no latch is inferred.
        map_d     = map_q;
        if (alloc) map_d[rd] = head_preg;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_AREGS; i++) map_q[i] <= PW'(i);
            for (int i = 0; i < FL; i++) fl_mem[i] <= PW'(NUM_AREGS + i);
            fl_head     <= '0;
            fl_tail     <= '{wrap: 1'b1, idx: '0};
            rob_ctr     <= '0;
            ck_head     <= '0;
            ck_tail     <= '0;
            ck_done     <= '0;
            valid_out   <= 1'b0;
            ps1         <= '0;
            ps2         <= '0;
            pd_old      <= '0;
            pd_new      <= '0;
            rob_tag     <= '0;
            ckpt_id     <= '0;
            payload_out <= '0;
        end else begin
            // Frees land at the tail whether or not a recovery happens this cycle.
            if (push) begin
                fl_mem[fl_tail.idx] <= free_preg;
                fl_tail             <= fl_inc(fl_tail);
            end
            if (flush) begin
                valid_out <= 1'b0;
                if (res_live) begin
                    map_q   <= ck_map[resolve_ckpt];
                    fl_head <= ck_flh[resolve_ckpt];
                    rob_ctr <= ck_rob[resolve_ckpt];
                    ck_tail <= ck_head + {1'b0, res_off};
                end
            end else begin
                map_q <= map_d;
                if (alloc)  fl_head <= fl_inc(fl_head);
                if (retire) ck_head <= ck_head + (CW+1)'(1);
                if (resolve_valid && res_live) ck_done[resolve_ckpt] <= 1'b1;
                if (accept) begin
                    valid_out   <= 1'b1;
                    ps1         <= map_q[rs1];
                    ps2         <= map_q[rs2];
                    pd_old      <= map_q[rd];
                    pd_new      <= write_pd ? head_preg : '0;
                    rob_tag     <= rob_ctr;
                    ckpt_id     <= is_br ? ck_tail[CW-1:0] : '0;
                    payload_out <= payload_in;
                    rob_ctr     <= rob_next;
                    if (is_br) begin
                        ck_tail                   <= ck_tail + (CW+1)'(1);
                        ck_done[ck_tail[CW-1:0]]  <= 1'b0;
                    end
                end else if (ready_out) begin
                    valid_out <= 1'b0;
                end
            end
        end
    end

    // NOTE: checkpoint storage has no reset; a slot is only read after a branch has written it.
    always_ff @(posedge clk) begin
        if (accept && is_br) begin
            ck_map[ck_tail[CW-1:0]] <= map_q;
            ck_flh[ck_tail[CW-1:0]] <= fl_head;
            ck_rob[ck_tail[CW-1:0]] <= rob_next;
        end
    end

endmodule

// File: tb/tb_rename_ckpt.sv
// Bench for rename_ckpt: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based behavioural model.
module tb_rename_ckpt;

    localparam int NA = 32, NP = 128, RD = 16, NC = 4, PLW = 64;
    localparam int AW = 5, PW = 7, TW = 4, CW = 2, FL = NP - NA;
    localparam logic [6:0] OP_ALU = 7'b0110011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011, OP_BR = 7'b1100011;

    typedef logic [NA-1:0][PW-1:0] map_t;

    logic           clk, reset;
    logic           valid_in, ready_in, valid_out, ready_out;
    logic [AW-1:0]  rs1, rs2, rd;
    logic [6:0]     opcode;
    logic [PLW-1:0] payload_in, payload_out;
    logic [PW-1:0]  ps1, ps2, pd_old, pd_new, free_preg;
    logic [TW-1:0]  rob_tag;
    logic [CW-1:0]  ckpt_id, resolve_ckpt;
    logic           free_valid, resolve_valid, resolve_mispredict;

    rename_ckpt #(.NUM_AREGS(NA), .NUM_PREGS(NP), .ROB_DEPTH(RD), .NUM_CKPT(NC), .PAYLOAD_W(PLW)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode), .payload_in(payload_in),
        .valid_out(valid_out), .ready_out(ready_out), .ps1(ps1), .ps2(ps2),
        .pd_old(pd_old), .pd_new(pd_new), .rob_tag(rob_tag), .ckpt_id(ckpt_id),
        .payload_out(payload_out), .free_valid(free_valid), .free_preg(free_preg),
        .resolve_valid(resolve_valid), .resolve_ckpt(resolve_ckpt),
        .resolve_mispredict(resolve_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    // Behavioural model: free list is an ever-growing log of pushed pregs with an
    // absolute head index; checkpoints are parallel queues, oldest at the front.
    map_t           m_map;
    int             fl_log[$];
    int             m_head, m_rob, m_tail_slot;
    int             ck_id[$], ck_fh[$], ck_rob[$];
    bit             ck_done[$];
    map_t           ck_map[$];
    bit             e_valid, e_br;
    int             e_ps1, e_ps2, e_pdo, e_pdn, e_tag, e_ck;
    logic [PLW-1:0] e_pay;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_wp();
        return (opcode != OP_ST) && (opcode != OP_BR) && (rd != 0);
    endfunction

    function automatic int m_find(input int k);
        foreach (ck_id[i]) if (ck_id[i] == k) return i;
        return -1;
    endfunction

    function automatic bit m_ready();
        return reset && !(resolve_valid && resolve_mispredict) && (ready_out || !e_valid)
               && (!m_wp() || m_head < fl_log.size())
               && ((opcode != OP_BR) || ck_id.size() < NC);
    endfunction

    task automatic m_truncate(input int n);
        while (ck_id.size() > n) begin
            void'(ck_id.pop_back()); void'(ck_fh.pop_back()); void'(ck_rob.pop_back());
            void'(ck_done.pop_back()); void'(ck_map.pop_back());
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NA; i++) m_map[i] = PW'(i);
        fl_log.delete();
        for (int i = NA; i < NP; i++) fl_log.push_back(i);
        m_head = 0; m_rob = 0; m_tail_slot = 0;
        m_truncate(0);
        e_valid = 0; e_br = 0; e_ps1 = 0; e_ps2 = 0; e_pdo = 0; e_pdn = 0;
        e_tag = 0; e_ck = 0; e_pay = '0;
    endtask

    task automatic m_step();
        bit fl, acc, ret;
        int idx;
        if (!reset) begin
            m_reset();
            return;
        end
        fl  = resolve_valid && resolve_mispredict;
        acc = valid_in && m_ready();
        idx = resolve_valid ? m_find(int'(resolve_ckpt)) : -1;
        ret = (ck_id.size() > 0) && ck_done[0];
        if (fl) begin
            if (idx >= 0) begin
                m_map = ck_map[idx]; m_head = ck_fh[idx]; m_rob = ck_rob[idx];
                m_truncate(idx);
                m_tail_slot = int'(resolve_ckpt);
            end
            e_valid = 0;
        end else begin
            if (idx >= 0) ck_done[idx] = 1'b1;
            if (acc) begin
                e_ps1 = m_map[rs1]; e_ps2 = m_map[rs2]; e_pdo = m_map[rd];
                e_tag = m_rob; e_pay = payload_in; e_br = (opcode == OP_BR); e_valid = 1;
                if (m_wp()) begin
                    e_pdn = fl_log[m_head];
                    m_head++;
                    m_map[rd] = PW'(e_pdn);
                end else begin
                    e_pdn = 0;
                end
                m_rob = (m_rob + 1) % RD;
                if (e_br) begin
                    e_ck = m_tail_slot;
                    ck_id.push_back(m_tail_slot); ck_map.push_back(m_map);
                    ck_fh.push_back(m_head); ck_rob.push_back(m_rob); ck_done.push_back(1'b0);
                    m_tail_slot = (m_tail_slot + 1) % NC;
                end
            end else if (ready_out) begin
                e_valid = 0;
            end
            if (ret) begin
                void'(ck_id.pop_front()); void'(ck_fh.pop_front()); void'(ck_rob.pop_front());
                void'(ck_done.pop_front()); void'(ck_map.pop_front());
            end
        end
        if (free_valid && free_preg != 0) fl_log.push_back(int'(free_preg));
    endtask

    task automatic cmp_outputs();
        check("valid_out", valid_out, e_valid);
        if (e_valid) begin
            check("ps1", ps1, e_ps1);
            check("ps2", ps2, e_ps2);
            check("pd_old", pd_old, e_pdo);
            check("pd_new", pd_new, e_pdn);
            check("rob_tag", rob_tag, e_tag);
            check("payload_out", payload_out, e_pay);
            if (e_br) check("ckpt_id", ckpt_id, e_ck);
        end
    endtask

    task automatic step();
        #1;
        check("ready_in", ready_in, m_ready());
        @(posedge clk);
        m_step();
        #1;
        cmp_outputs();
    endtask

    task automatic idle();
        valid_in = 0; opcode = OP_ALU; rs1 = 0; rs2 = 0; rd = 0; payload_in = '0;
        ready_out = 1; free_valid = 0; free_preg = 0;
        resolve_valid = 0; resolve_ckpt = 0; resolve_mispredict = 0;
    endtask

    task automatic set_ins(input logic [6:0] op, input int d, input int s1, input int s2);
        valid_in = 1; opcode = op; rd = AW'(d); rs1 = AW'(s1); rs2 = AW'(s2);
        payload_in = {$urandom(), $urandom()};
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        step();
        step();
        reset = 1;
    endtask

    initial begin
        reset = 0;
        idle();
        m_reset();

        // Reset state and the first two dependent instructions.
        do_reset();
        check("rst_valid", valid_out, 0);
        check("rst_fields", {ps1, ps2, pd_old, pd_new, rob_tag, ckpt_id}, 0);
        check("rst_payload", payload_out, 0);
        set_ins(OP_ALU, 1, 2, 3); step();
        check("add_ps1", ps1, 2); check("add_ps2", ps2, 3); check("add_pd_old", pd_old, 1);
        check("add_pd_new", pd_new, 32); check("add_tag", rob_tag, 0);
        set_ins(OP_ALU, 4, 1, 1); step();
        check("sub_ps1", ps1, 32); check("sub_ps2", ps2, 32); check("sub_pd_new", pd_new, 33);

        // Drain the free list, stall, then unstall with a free.
        for (int i = 0; i < 94; i++) begin
            set_ins(OP_ALU, 1 + $urandom_range(30), $urandom_range(31), $urandom_range(31));
            step();
        end
        set_ins(OP_ALU, 6, 1, 2);
        #1 check("stall_97", ready_in, 0);
        step();
        free_valid = 1; free_preg = 1;
        #1 check("stall_same_cycle_free", ready_in, 0);
        step();
        free_valid = 0;
        #1 check("unstall_97", ready_in, 1);
        step();
        check("pd_new_recycled", pd_new, 1);

        // Non-allocating instructions and the ignored free of preg 0.
        set_ins(OP_ST, 5, 6, 7); step();
        check("store_pd_new", pd_new, 0);
        set_ins(OP_ALU, 0, 5, 5); step();
        check("x0_pd_new", pd_new, 0);
        set_ins(OP_ST, 0, 5, 6); step();
        idle(); free_valid = 1; free_preg = 0; step();
        free_valid = 0;
        set_ins(OP_ALU, 7, 1, 1);
        #1 check("free0_ignored", ready_in, 0);
        step();

        // Checkpoint capacity and in-order retire.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_ins(OP_BR, 0, i + 1, i + 2); step();
            check("br_ckpt_id", ckpt_id, i);
        end
        set_ins(OP_BR, 0, 1, 2);
        #1 check("br5_stall", ready_in, 0);
        resolve_valid = 1; resolve_ckpt = 0; resolve_mispredict = 0;
        step();
        resolve_valid = 0;
        #1;
        for (int n = 0; n < 4 && ready_in !== 1'b1; n++) begin
            step();
            #1;
        end
        check("br5_unstall", ready_in, 1);
        step();
        check("br5_ckpt_id", ckpt_id, 0);

        // Mispredict recovery of a middle checkpoint.
        do_reset();
        set_ins(OP_BR, 0, 1, 2); step();
        set_ins(OP_BR, 0, 1, 2); step();
        check("brB_ckpt", ckpt_id, 1);
        set_ins(OP_ALU, 3, 1, 2); step();
        set_ins(OP_ALU, 4, 3, 3); step();
        set_ins(OP_BR, 0, 3, 4); step();
        set_ins(OP_ALU, 5, 4, 3); step();
        set_ins(OP_BR, 0, 5, 5); step();
        check("brD_ckpt", ckpt_id, 3);
        idle(); resolve_valid = 1; resolve_ckpt = 1; resolve_mispredict = 1;
        step();
        check("flush_valid", valid_out, 0);
        idle();
        set_ins(OP_ALU, 3, 3, 4); step();
        check("rec_ps1", ps1, 3); check("rec_ps2", ps2, 4);
        check("rec_pd_new", pd_new, 32); check("rec_tag", rob_tag, 2);
        for (int i = 1; i < 4; i++) begin
            set_ins(OP_BR, 0, 1, 1); step();
            check("rec_br_ckpt", ckpt_id, i);
        end
        set_ins(OP_BR, 0, 1, 1);
        #1 check("rec_full", ready_in, 0);
        step();

        // ROB tag wrap, output hold, mid-stream reset.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_ins((i % 3 == 0) ? OP_ST : OP_ALU, 1 + $urandom_range(30), $urandom_range(31), $urandom_range(31));
            step();
            check("tag_seq", rob_tag, i % 16);
        end
        ready_out = 0;
        set_ins(OP_ALU, 2, 3, 4);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_valid", valid_out, 1);
            check("hold_tag", rob_tag, 0);
        end
        reset = 0;
        step();
        check("midrst_valid", valid_out, 0);
        reset = 1; idle();
        set_ins(OP_ALU, 9, 7, 9); step();
        check("midrst_ps1", ps1, 7); check("midrst_ps2", ps2, 9);
        check("midrst_pd_old", pd_old, 9); check("midrst_pd_new", pd_new, 32);
        check("midrst_tag", rob_tag, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int r, min_head;
            idle();
            reset     = ($urandom_range(499) != 0);
            ready_out = ($urandom_range(3) != 0);
            if ($urandom_range(9) < 7) begin
                r = $urandom_range(9);
                set_ins(r < 5 ? OP_ALU : r < 7 ? OP_ST : r < 9 ? OP_BR : OP_LD,
                        ($urandom_range(7) == 0) ? 0 : $urandom_range(31),
                        $urandom_range(31), $urandom_range(31));
            end
            min_head = (ck_fh.size() > 0) ? ck_fh[0] : m_head;
            if ($urandom_range(2) == 0 && (fl_log.size() + 1 - min_head) <= FL) begin
                free_valid = 1;
                free_preg  = PW'($urandom_range(NP - 1));
            end
            if ($urandom_range(5) == 0) begin
                resolve_valid      = 1;
                resolve_ckpt       = CW'($urandom_range(NC - 1));
                resolve_mispredict = ($urandom_range(3) == 0) && (m_find(int'(resolve_ckpt)) >= 0);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
